// File: rtl/mano_pkg.sv
// Shared encodings for the Mano basic computer control unit: bus sources,
// ALU functions, memory-reference opcodes and register-reference bit positions.
package mano_pkg;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    typedef enum logic [2:0] {
        ALU_AND     = 3'd0,
        ALU_ADD     = 3'd1,
        ALU_PASS_DR = 3'd2,
        ALU_CMA     = 3'd3,
        ALU_CIR     = 3'd4,
        ALU_CIL     = 3'd5
    } alu_sel_t;

    localparam logic [2:0] D_AND = 3'd0;
    localparam logic [2:0] D_ADD = 3'd1;
    localparam logic [2:0] D_LDA = 3'd2;
    localparam logic [2:0] D_STA = 3'd3;
    localparam logic [2:0] D_BUN = 3'd4;
    localparam logic [2:0] D_BSA = 3'd5;
    localparam logic [2:0] D_ISZ = 3'd6;
    localparam logic [2:0] D_IO  = 3'd7;

    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

endpackage

// File: rtl/mano_rr_decode.sv
// Register-reference decode: resolves AC-op and E-op priorities and the skip test.
module mano_rr_decode
    import mano_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [11:0]   rr,
    input  logic [DW-1:0] ac,
    input  logic          e,
    output alu_sel_t      alu_sel,
    output logic          ac_write,
    output logic          ac_increment,
    output logic          ac_clear,
    output logic          e_write,
    output logic          e_clear,
    output logic          e_complement,
    output logic          pc_increment,
    output logic          halt
);

    always_comb begin
        alu_sel      = ALU_AND;
        ac_write     = 1'b0;
        ac_increment = 1'b0;
        ac_clear     = 1'b0;
        e_write      = 1'b0;
        if (rr[RR_CLA]) begin
            ac_clear = 1'b1;
        end else if (rr[RR_CMA]) begin
            alu_sel  = ALU_CMA;
            ac_write = 1'b1;
        end else if (rr[RR_CIR]) begin
            alu_sel  = ALU_CIR;
            ac_write = 1'b1;
            e_write  = 1'b1;
        end else if (rr[RR_CIL]) begin
            alu_sel  = ALU_CIL;
            ac_write = 1'b1;
            e_write  = 1'b1;
        end else if (rr[RR_INC]) begin
            ac_increment = 1'b1;
        end
    end

    // A rotate already loads E from the carry, so CLE/CME lose to it.
    assign e_clear      = rr[RR_CLE] & ~e_write;
    assign e_complement = rr[RR_CME] & ~rr[RR_CLE] & ~e_write;

    assign pc_increment = (rr[RR_SPA] & ~ac[DW-1]) |
                          (rr[RR_SNA] &  ac[DW-1]) |
                          (rr[RR_SZA] & (ac == '0)) |
                          (rr[RR_SZE] & ~e);

    assign halt = rr[RR_HLT];

endmodule

// File: rtl/mano_control_unit.sv
// Hardwired control for the Mano basic computer: sequence counter plus
// combinational strobe decode of (SC, I, IR, AC, DR, E, halted).
module mano_control_unit
    import mano_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] IR,
    input  logic [DW-1:0] AC,
    input  logic [DW-1:0] DR,
    input  logic          E,
    output logic [2:0]    BUS_SEL,
    output logic [2:0]    ALU_SEL,
    output logic          MEM_write,
    output logic          AR_write,
    output logic          AR_increment,
    output logic          AR_clear,
    output logic          PC_write,
    output logic          PC_increment,
    output logic          PC_clear,
    output logic          DR_write,
    output logic          DR_increment,
    output logic          DR_clear,
    output logic          AC_write,
    output logic          AC_increment,
    output logic          AC_clear,
    output logic          IR_write,
    output logic          TR_write,
    output logic          TR_increment,
    output logic          TR_clear,
    output logic          OUTR_write,
    output logic          E_write,
    output logic          E_clear,
    output logic          E_complement,
    output logic          halted,
    output logic [2:0]    SC
);

    logic [2:0] sc;
    logic       i_reg;
    logic [2:0] d;
    alu_sel_t   alu;

    alu_sel_t   rr_alu;
    logic       rr_ac_write, rr_ac_increment, rr_ac_clear;
    logic       rr_e_write, rr_e_clear, rr_e_complement;
    logic       rr_pc_increment, rr_halt;

    // Opcode sits directly above the address field.
    assign d       = IR[AW+2:AW];
    assign SC      = sc;
    assign ALU_SEL = alu;

    assign AR_clear     = 1'b0;
    assign DR_clear     = 1'b0;
    assign TR_write     = 1'b0;
    assign TR_increment = 1'b0;
    assign TR_clear     = 1'b0;
    assign OUTR_write   = 1'b0;

    mano_rr_decode #(.DW(DW)) u_rr (
        .rr           (IR[11:0]),
        .ac           (AC),
        .e            (E),
        .alu_sel      (rr_alu),
        .ac_write     (rr_ac_write),
        .ac_increment (rr_ac_increment),
        .ac_clear     (rr_ac_clear),
        .e_write      (rr_e_write),
        .e_clear      (rr_e_clear),
        .e_complement (rr_e_complement),
        .pc_increment (rr_pc_increment),
        .halt         (rr_halt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc     <= 3'd0;
            i_reg  <= 1'b0;
            halted <= 1'b0;
        end else if (!halted) begin
            case (sc)
                3'd0, 3'd1: sc <= sc + 3'd1;
                3'd2: begin
                    i_reg <= IR[DW-1];
                    sc    <= 3'd3;
                end
                3'd3: begin
                    if (d == D_IO) begin
                        sc <= 3'd0;
                        if (!i_reg && rr_halt) halted <= 1'b1;
                    end else begin
                        sc <= 3'd4;
                    end
                end
                3'd4:    sc <= (d == D_STA || d == D_BUN) ? 3'd0 : 3'd5;
                3'd5:    sc <= (d == D_ISZ) ? 3'd6 : 3'd0;
                default: sc <= 3'd0;
            endcase
        end
    end

    always_comb begin
        BUS_SEL      = BUS_NONE;
        alu          = ALU_AND;
        MEM_write    = 1'b0;
        AR_write     = 1'b0;
        AR_increment = 1'b0;
        PC_write     = 1'b0;
        PC_increment = 1'b0;
        PC_clear     = 1'b0;
        DR_write     = 1'b0;
        DR_increment = 1'b0;
        AC_write     = 1'b0;
        AC_increment = 1'b0;
        AC_clear     = 1'b0;
        IR_write     = 1'b0;
        E_write      = 1'b0;
        E_clear      = 1'b0;
        E_complement = 1'b0;
        if (reset) begin
            PC_clear = 1'b1;
        end else if (!halted) begin
            case (sc)
                3'd0: begin
                    BUS_SEL  = BUS_PC;
                    AR_write = 1'b1;
                end
                3'd1: begin
                    BUS_SEL      = BUS_MEM;
                    IR_write     = 1'b1;
                    PC_increment = 1'b1;
                end
                3'd2: begin
                    BUS_SEL  = BUS_IR;
                    AR_write = 1'b1;
                end
                3'd3: begin
                    if (d != D_IO) begin
                        if (i_reg) begin
                            BUS_SEL  = BUS_MEM;
                            AR_write = 1'b1;
                        end
                    end else if (!i_reg) begin
                        alu          = rr_alu;
                        AC_write     = rr_ac_write;
                        AC_increment = rr_ac_increment;
                        AC_clear     = rr_ac_clear;
                        E_write      = rr_e_write;
                        E_clear      = rr_e_clear;
                        E_complement = rr_e_complement;
                        PC_increment = rr_pc_increment;
                    end
                end
                3'd4: begin
                    case (d)
                        D_AND, D_ADD, D_LDA, D_ISZ: begin
                            BUS_SEL  = BUS_MEM;
                            DR_write = 1'b1;
                        end
                        D_STA: begin
                            BUS_SEL   = BUS_AC;
                            MEM_write = 1'b1;
                        end
                        D_BUN: begin
                            BUS_SEL  = BUS_AR;
                            PC_write = 1'b1;
                        end
                        D_BSA: begin
                            BUS_SEL      = BUS_PC;
                            MEM_write    = 1'b1;
                            AR_increment = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd5: begin
                    case (d)
                        D_AND: begin
                            alu      = ALU_AND;
                            AC_write = 1'b1;
                        end
                        D_ADD: begin
                            alu      = ALU_ADD;
                            AC_write = 1'b1;
                            E_write  = 1'b1;
                        end
                        D_LDA: begin
                            alu      = ALU_PASS_DR;
                            AC_write = 1'b1;
                        end
                        D_BSA: begin
                            BUS_SEL  = BUS_AR;
                            PC_write = 1'b1;
                        end
                        D_ISZ:   DR_increment = 1'b1;
                        default: ;
                    endcase
                end
                3'd6: begin
                    if (d == D_ISZ) begin
                        BUS_SEL      = BUS_DR;
                        MEM_write    = 1'b1;
                        PC_increment = (DR == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mano_control_unit.sv
// Randomized bench: each instruction is expanded into its expected
// micro-operation trace and compared cycle by cycle against the control unit.
module tb_mano_control_unit;

    logic        clk;
    logic        reset;
    logic [15:0] IR, AC, DR;
    logic        E;
    logic [2:0]  BUS_SEL, ALU_SEL, SC;
    logic MEM_write, AR_write, AR_increment, AR_clear, PC_write, PC_increment, PC_clear;
    logic DR_write, DR_increment, DR_clear, AC_write, AC_increment, AC_clear, IR_write;
    logic TR_write, TR_increment, TR_clear, OUTR_write, E_write, E_clear, E_complement, halted;

    mano_control_unit #(.AW(12), .DW(16)) dut (
        .clk(clk), .reset(reset), .IR(IR), .AC(AC), .DR(DR), .E(E),
        .BUS_SEL(BUS_SEL), .ALU_SEL(ALU_SEL), .MEM_write(MEM_write),
        .AR_write(AR_write), .AR_increment(AR_increment), .AR_clear(AR_clear),
        .PC_write(PC_write), .PC_increment(PC_increment), .PC_clear(PC_clear),
        .DR_write(DR_write), .DR_increment(DR_increment), .DR_clear(DR_clear),
        .AC_write(AC_write), .AC_increment(AC_increment), .AC_clear(AC_clear),
        .IR_write(IR_write), .TR_write(TR_write), .TR_increment(TR_increment),
        .TR_clear(TR_clear), .OUTR_write(OUTR_write), .E_write(E_write),
        .E_clear(E_clear), .E_complement(E_complement), .halted(halted), .SC(SC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] bus;
        logic [2:0] alu;
        logic mem_w, ar_w, ar_i, pc_w, pc_i, pc_c, dr_w, dr_i;
        logic ac_w, ac_i, ac_c, ir_w, e_w, e_c, e_cm, halted;
        logic [5:0] spare;
        logic [2:0] sc;
    } obs_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.bus = BUS_SEL;  o.alu = ALU_SEL;
        o.mem_w = MEM_write; o.ar_w = AR_write; o.ar_i = AR_increment;
        o.pc_w = PC_write; o.pc_i = PC_increment; o.pc_c = PC_clear;
        o.dr_w = DR_write; o.dr_i = DR_increment;
        o.ac_w = AC_write; o.ac_i = AC_increment; o.ac_c = AC_clear;
        o.ir_w = IR_write; o.e_w = E_write; o.e_c = E_clear; o.e_cm = E_complement;
        o.halted = halted;
        o.spare = {AR_clear, DR_clear, TR_write, TR_increment, TR_clear, OUTR_write};
        o.sc = SC;
        return o;
    endfunction

    function automatic obs_t idle(input int t);
        obs_t o = '0;
        o.sc = 3'(t);
        return o;
    endfunction

    // ALU code only matters when the accumulator is actually loaded.
    task automatic cmp_step(input string tag, input obs_t exp);
        obs_t got = sample();
        if (!exp.ac_w) got.alu = exp.alu;
        chk(tag, got, exp);
    endtask

    // Expand one instruction into its expected per-cycle trace and check it.
    // stop >= 0 runs only the first 'stop' cycles (used for mid-instruction reset).
    task automatic run_instr(input string name, input logic [15:0] ir, input logic [15:0] ac,
                             input logic [15:0] dr, input logic e, input int stop);
        obs_t q[$];
        obs_t o;
        int   d   = int'(ir[14:12]);
        bit   ind = ir[15];
        int   n;
        IR = ir; AC = ac; DR = dr; E = e;

        o = idle(0); o.bus = 3'd2; o.ar_w = 1; q.push_back(o);
        o = idle(1); o.bus = 3'd7; o.ir_w = 1; o.pc_i = 1; q.push_back(o);
        o = idle(2); o.bus = 3'd5; o.ar_w = 1; q.push_back(o);
        o = idle(3);
        if (d == 7) begin
            if (!ind) begin
                if (ir[11])     o.ac_c = 1;
                else if (ir[9]) begin o.alu = 3'd3; o.ac_w = 1; end
                else if (ir[7]) begin o.alu = 3'd4; o.ac_w = 1; o.e_w = 1; end
                else if (ir[6]) begin o.alu = 3'd5; o.ac_w = 1; o.e_w = 1; end
                else if (ir[5]) o.ac_i = 1;
                if (!o.e_w) begin
                    if (ir[10])     o.e_c  = 1;
                    else if (ir[8]) o.e_cm = 1;
                end
                o.pc_i = (ir[4] && !ac[15]) || (ir[3] && ac[15]) ||
                         (ir[2] && ac == 0) || (ir[1] && !e);
            end
            q.push_back(o);
        end else begin
            if (ind) begin o.bus = 3'd7; o.ar_w = 1; end
            q.push_back(o);
            o = idle(4);
            case (d)
                0, 1, 2: begin
                    o.bus = 3'd7; o.dr_w = 1; q.push_back(o);
                    o = idle(5); o.ac_w = 1; o.alu = (d == 0) ? 3'd0 : (d == 1) ? 3'd1 : 3'd2;
                    o.e_w = (d == 1); q.push_back(o);
                end
                3: begin o.bus = 3'd4; o.mem_w = 1; q.push_back(o); end
                4: begin o.bus = 3'd1; o.pc_w = 1; q.push_back(o); end
                5: begin
                    o.bus = 3'd2; o.mem_w = 1; o.ar_i = 1; q.push_back(o);
                    o = idle(5); o.bus = 3'd1; o.pc_w = 1; q.push_back(o);
                end
                default: begin
                    o.bus = 3'd7; o.dr_w = 1; q.push_back(o);
                    o = idle(5); o.dr_i = 1; q.push_back(o);
                    o = idle(6); o.bus = 3'd3; o.mem_w = 1; o.pc_i = (dr == 0); q.push_back(o);
                end
            endcase
        end

        n = (stop >= 0 && stop < q.size()) ? stop : q.size();
        for (int k = 0; k < n; k++) begin
            #1;
            cmp_step($sformatf("%s ir=%h T%0d", name, ir, k), q[k]);
            @(negedge clk);
        end
    endtask

    task automatic check_reset_state(input string tag);
        obs_t o = idle(0);
        o.pc_c = 1;
        #1;
        chk(tag, sample(), o);
    endtask

    initial begin
        logic [15:0] ir, ac, dr;
        int d;
        reset = 1'b1; IR = '0; AC = '0; DR = '0; E = 1'b0;
        #2;
        check_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_instr("lda",       16'h2005, 16'h1234, 16'h0042, 1'b0, -1);
        run_instr("and_ind",   16'h8005, 16'h00FF, 16'h0F0F, 1'b1, -1);
        run_instr("isz_zero",  16'h6010, 16'h0000, 16'h0000, 1'b0, -1);
        run_instr("isz_nz",    16'h6010, 16'h0000, 16'h0001, 1'b0, -1);
        run_instr("spa_pos",   16'h7010, 16'h7FFF, 16'h0000, 1'b0, -1);
        run_instr("spa_neg",   16'h7010, 16'h8000, 16'h0000, 1'b0, -1);
        run_instr("cla_cma",   16'h7A00, 16'h5555, 16'h0000, 1'b0, -1);
        run_instr("cir_cle",   16'h7480, 16'h0001, 16'h0000, 1'b1, -1);
        run_instr("sze",       16'h7002, 16'h0001, 16'h0000, 1'b0, -1);
        run_instr("io_nop",    16'hF001, 16'h0000, 16'h0000, 1'b0, -1);

        for (int i = 0; i < 150; i++) begin
            d  = int'($urandom_range(0, 7));
            ir = 16'($urandom);
            ir[14:12] = 3'(d);
            if (d == 7 && !ir[15]) ir[11:0] = 12'($urandom & $urandom) & 12'hFFE;
            case ($urandom_range(0, 3))
                0:       ac = 16'h0000;
                1:       ac = 16'h8000;
                2:       ac = 16'h7FFF;
                default: ac = 16'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0:       dr = 16'h0000;
                1:       dr = 16'h0001;
                default: dr = 16'($urandom);
            endcase
            run_instr("rand", ir, ac, dr, 1'($urandom), -1);
        end

        // Abort an ADD after its decode cycles; the next instruction starts clean.
        run_instr("add_part", 16'h1234, 16'h0001, 16'h0002, 1'b0, 4);
        #2 reset = 1'b1;
        check_reset_state("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        run_instr("bsa_after", 16'h5123, 16'h0000, 16'h0000, 1'b0, -1);

        run_instr("hlt", 16'h7001, 16'h0000, 16'h0000, 1'b0, -1);
        for (int k = 0; k < 10; k++) begin
            obs_t o = idle(0);
            o.halted = 1;
            #1;
            chk($sformatf("halted c%0d", k), sample(), o);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        check_reset_state("reset_halt");
        @(negedge clk);
        reset = 1'b0;
        run_instr("sta_after", 16'h3077, 16'hABCD, 16'h0000, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
